mca_stream_sequencer: RTL

- Producer/consumer front end for the LUT4 multi-clock FIR adder. It packs the incoming N-bit control-vector stream into the K-bit S_matrix history and issues start pulses at the downsampled rate.
- It holds S_matrix stable while the adder computes, captures the adder's sample after a fixed latency, and presents it on a valid/ready output.
- It sits between the control-bit source and the mca_single_as/multi_clk_adder datapath.

---
 rtl/FIR_pkg.sv | 17 +
 rtl/mca_s_shift_reg.sv | 34 +++
 rtl/mca_stream_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/FIR_pkg.sv
// Shared types and helpers for the LUT4 multi-clock FIR front end.
// Holds the sequencer state encoding and the counter-width helper.
package FIR_pkg;

  typedef enum logic [1:0] {
    SEQ_FILL,
    SEQ_ACC,
    SEQ_BUSY,
    SEQ_DONE
  } seq_state_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int seq_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mca_s_shift_reg.sv
// K-bit control history; newest N-bit word enters at the low end.
// Ports: clk, reset (sync, high), shift_en, din[N-1:0], S_matrix[K-1:0].
module mca_s_shift_reg #(
  parameter int K = 256,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en,
  input  logic [N-1:0] din,
  output logic [K-1:0] S_matrix
);

  logic [K-1:0] s_q;
  logic [K-1:0] s_d;

  always_comb begin
    s_d = s_q;
    if (shift_en) begin
      s_d = {s_q[K-N-1:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign S_matrix = s_q;

endmodule

// File: rtl/mca_stream_sequencer.sv
// Packs control words into S_matrix, fires decimated starts to the
// adder, captures its sample after a fixed latency and offers it on a
// valid/ready output. Ports: clk, reset (sync, high); in_valid/in_ready/
// in_s input stream; S_matrix, start to the adder; sample from the
// adder; out_valid/out_ready/out_sample output stream.
// Optional macro MCA_SEQ_STALL_CNT_EN adds the stall_cnt[15:0] port.
module mca_stream_sequencer
  import FIR_pkg::*;
#(
  parameter int K                 = 256,
  parameter int N                 = 8,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int DOWNSAMPLE        = 4,
  parameter int MCA_LATENCY       = 34
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N-1:0]                        in_s,
  output logic [K-1:0]                        S_matrix,
  output logic                                start,
  input  logic signed [WIDTH_COEFFICIENT-1:0] sample,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [WIDTH_COEFFICIENT-1:0] out_sample
`ifdef MCA_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]                         stall_cnt
`endif
);

  localparam int FW = seq_cnt_w(K / N);
  localparam int DW = seq_cnt_w(DOWNSAMPLE);
  localparam int LW = seq_cnt_w(MCA_LATENCY);

  localparam logic [FW-1:0] FILL_LAST = FW'(K / N - 1);
  localparam logic [DW-1:0] DEC_LAST  = DW'(DOWNSAMPLE - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(MCA_LATENCY - 1);

  seq_state_t                          state_q;
  logic [FW-1:0]                       fill_cnt_q;
  logic [DW-1:0]                       dec_cnt_q;
  logic [LW-1:0]                       lat_cnt_q;
  logic                                start_q;
  logic                                out_valid_q;
  logic signed [WIDTH_COEFFICIENT-1:0] out_sample_q;
  logic                                accept;

  // S_matrix only moves while collecting words, so it is frozen
  // for the adder throughout BUSY and DONE.
  assign in_ready = (state_q == SEQ_FILL) || (state_q == SEQ_ACC);
  assign accept   = in_valid && in_ready;

  mca_s_shift_reg #(
    .K(K),
    .N(N)
  ) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .shift_en(accept),
    .din     (in_s),
    .S_matrix(S_matrix)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SEQ_FILL;
      fill_cnt_q   <= '0;
      dec_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      start_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      start_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        SEQ_FILL: begin
          if (accept) begin
            fill_cnt_q <= fill_cnt_q + FW'(1);
            if (fill_cnt_q == FILL_LAST) begin
              dec_cnt_q <= '0;
              state_q   <= SEQ_ACC;
            end
          end
        end
        SEQ_ACC: begin
          if (accept) begin
            dec_cnt_q <= dec_cnt_q + DW'(1);
            if (dec_cnt_q == DEC_LAST) begin
              start_q   <= 1'b1;
              lat_cnt_q <= '0;
              state_q   <= SEQ_BUSY;
            end
          end
        end
        SEQ_BUSY: begin
          lat_cnt_q <= lat_cnt_q + LW'(1);
          if (lat_cnt_q == LAT_LAST) begin
            state_q <= SEQ_DONE;
          end
        end
        SEQ_DONE: begin
          // A pending output blocks capture unless it drains now.
          if (!out_valid_q || out_ready) begin
            out_sample_q <= sample;
            out_valid_q  <= 1'b1;
            dec_cnt_q    <= '0;
            state_q      <= SEQ_ACC;
          end
        end
        default: state_q <= SEQ_FILL;
      endcase
    end
  end

  assign start      = start_q;
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;

`ifdef MCA_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] stall_d;

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
